// File: rtl/mul_operand_dispatcher.sv
// Operand FIFO and handshake sequencer in front of a sequential multiplier.
// Issues one start pulse per queued pair and returns tagged products on a valid/ready port.
`timescale 1ns/1ps

module mul_operand_dispatcher #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int MIN_LAT = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_a,
  input  logic [DATA_W-1:0]         in_b,
  output logic                      mul_start,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic                      mul_ready,
  input  logic [2*DATA_W-1:0]       mul_product,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*DATA_W-1:0]       res_product,
  output logic [DATA_W-1:0]         res_a,
  output logic [DATA_W-1:0]         res_b,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy,
  output logic                      err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  logic [2*DATA_W-1:0] mem [DEPTH];

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                mul_start_q, mul_start_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d;
  logic [DATA_W-1:0]   mul_b_q, mul_b_d;
  logic                res_valid_q, res_valid_d;
  logic [2*DATA_W-1:0] res_product_q, res_product_d;
  logic [DATA_W-1:0]   res_a_q, res_a_d;
  logic [DATA_W-1:0]   res_b_q, res_b_d;
  logic                err_q, err_d;

  logic push;
  logic pop;

  // Full blocks pushes even when a pop happens the same cycle: no bypass path.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (count_q != '0) && mul_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise a path
    // that skips the assignment infers a latch.
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wait_cnt_d    = wait_cnt_q;
    mul_start_d   = 1'b0;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    res_valid_d   = res_valid_q;
    res_product_d = res_product_q;
    res_a_d       = res_a_q;
    res_b_d       = res_b_q;
    err_d         = err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        // The head is loaded together with the pop, so operands are valid with the start pulse.
        if (pop) begin
          state_d            = S_ISSUE;
          mul_start_d        = 1'b1;
          {mul_a_d, mul_b_d} = mem[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if ((wait_cnt_q >= WC_W'(MIN_LAT)) && mul_ready) begin
          state_d       = S_HOLD;
          res_valid_d   = 1'b1;
          res_product_d = mul_product;
          res_a_d       = mul_a_q;
          res_b_d       = mul_b_q;
        end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wait_cnt_q    <= '0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_a_q       <= '0;
      res_b_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wait_cnt_q    <= wait_cnt_d;
      mul_start_q   <= mul_start_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
      res_a_q       <= res_a_d;
      res_b_q       <= res_b_d;
      err_q         <= err_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone decide
  // which entries are meaningful, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {in_a, in_b};
  end

  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign res_valid   = res_valid_q;
  assign res_product = res_product_q;
  assign res_a       = res_a_q;
  assign res_b       = res_b_q;
  assign count       = count_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign err         = err_q;

endmodule

// File: tb/tb_mul_operand_dispatcher.sv
// Bench for mul_operand_dispatcher: 10-cycle multiplier model, queue-based
// reference of accepted pairs, and per-scenario checks.
`timescale 1ns/1ps

module tb_mul_operand_dispatcher;

  localparam int MUL_LAT = 10;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        m_ready = 1'b1;
  logic [15:0] m_prod = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_product;
  logic [7:0]  res_a;
  logic [7:0]  res_b;
  logic [2:0]  count;
  logic        busy;
  logic        err;

  int    vectors = 0;
  int    miscompares = 0;
  int    start_cnt = 0;
  int    consec_err = 0;
  int    stable_err = 0;
  bit    hang = 1'b0;
  int    m_cnt = 0;
  pair_t exp_q[$];
  res_t  got_q[$];

  mul_operand_dispatcher dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(m_ready), .mul_product(m_prod),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .res_a(res_a), .res_b(res_b),
    .count(count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: drops ready on start, returns the product MUL_LAT cycles later.
  // It has no reset of its own, so it stays mid-operation across a dispatcher reset.
  always @(posedge clk) begin
    if (mul_start) begin
      m_ready <= 1'b0;
      m_cnt   <= MUL_LAT;
      m_prod  <= 16'(mul_a) * 16'(mul_b);
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (!hang) begin
      m_cnt   <= 0;
      m_ready <= 1'b1;
    end
  end

  logic        prev_start = 1'b0;
  logic        prev_hold = 1'b0;
  res_t        prev_res;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_start) begin
        start_cnt++;
        if (prev_start) consec_err++;
      end
      if (res_valid && prev_hold && ({res_a, res_b, res_product} !== prev_res)) stable_err++;
      if (res_valid && res_ready) got_q.push_back({res_a, res_b, res_product});
      prev_start = mul_start;
      prev_hold  = res_valid && !res_ready;
      prev_res   = {res_a, res_b, res_product};
    end else begin
      prev_start = 1'b0;
      prev_hold  = 1'b0;
    end
  end

  function automatic logic [63:0] outs_now();
    return {9'd0, mul_start, mul_a, mul_b, res_valid, res_product, res_a, res_b, count, busy, err};
  endfunction

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    in_valid = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL push_accept: pair %h,%h not accepted within %0d cycles", a, b, n);
    end else begin
      exp_q.push_back({a, b});
    end
  endtask

  task automatic wait_results(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (outs_now() !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", outs_now());
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bit ok;
    int s0;
    got_q.delete();
    exp_q.delete();
    s0 = start_cnt;
    push(8'h12, 8'h34);
    @(negedge clk);
    vectors++;
    if (mul_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single_start_early: got %b expected 0", mul_start);
    end
    @(negedge clk);
    vectors++;
    if (mul_start !== 1'b1 || mul_a !== 8'h12 || mul_b !== 8'h34) begin
      miscompares++;
      $display("FAIL single_start_latency: got start=%b a=%h b=%h expected 1,12,34", mul_start, mul_a, mul_b);
    end
    wait_results(1, 100, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_result_timeout: got %0d results expected 1", got_q.size());
    end else begin
      vectors++;
      if (got_q[0] !== {8'h12, 8'h34, 16'h03A8}) begin
        miscompares++;
        $display("FAIL single_result: got %h expected 123403a8", got_q[0]);
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (start_cnt - s0 !== 1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_starts_err: got starts=%0d err=%b expected 1,0", start_cnt - s0, err);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int s0;
    got_q.delete();
    exp_q.delete();
    s0 = start_cnt;
    push(8'hFF, 8'hFF);
    push(8'h00, 8'h7F);
    wait_results(2, 200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d results expected 2", got_q.size());
    end else begin
      vectors++;
      if (got_q[0].p !== 16'hFE01 || got_q[1].p !== 16'h0000) begin
        miscompares++;
        $display("FAIL b2b_order: got %h,%h expected fe01,0000", got_q[0].p, got_q[1].p);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (start_cnt - s0 !== 2) begin
      miscompares++;
      $display("FAIL b2b_starts: got %0d expected 2", start_cnt - s0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit blocked;
    int n;
    got_q.delete();
    exp_q.delete();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'($urandom), 8'($urandom));
    vectors++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full: got count=%0d in_ready=%b expected 4,0", count, in_ready);
    end
    n = 0;
    while (!res_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_hold: got res_valid=%b expected 1", res_valid);
    end
    in_valid = 1'b1;
    in_a = 8'hA5;
    in_b = 8'h5A;
    blocked = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) blocked = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (!blocked || count !== 3'd4 || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_sixth_blocked: got blocked=%b count=%0d results=%0d expected 1,4,0", blocked, count, got_q.size());
    end
    res_ready = 1'b1;
    wait_results(5, 300, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_drain_timeout: got %0d results expected 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== {exp_q[i].a, exp_q[i].b, 16'(exp_q[i].a) * 16'(exp_q[i].b)}) begin
        miscompares++;
        $display("FAIL bp_drain[%0d]: got %h expected a=%h b=%h", i, got_q[i], exp_q[i].a, exp_q[i].b);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int n;
    got_q.delete();
    exp_q.delete();
    hang = 1'b1;
    push(8'h0A, 8'h0B);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mul_start && n < 20);
    vectors++;
    if (mul_start !== 1'b1) begin
      miscompares++;
      $display("FAIL to_start: got mul_start=%b expected 1", mul_start);
    end
    @(posedge clk);
    #1;
    push(8'h0C, 8'h0D);
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 60);
    vectors++;
    if (err !== 1'b1 || n != 33) begin
      miscompares++;
      $display("FAIL to_err: got err=%b after %0d cycles expected 1 after 33", err, n);
    end
    void'(exp_q.pop_front());
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mul_start) seen = 1'b1;
    end
    vectors++;
    if (seen || count !== 3'd1) begin
      miscompares++;
      $display("FAIL to_no_issue: got start_seen=%b count=%0d expected 0,1", seen, count);
    end
    @(posedge clk);
    #1;
    hang = 1'b0;
    wait_results(1, 100, ok);
    vectors++;
    if (!ok || got_q[0] !== {8'h0C, 8'h0D, 16'h009C} || err !== 1'b1) begin
      miscompares++;
      $display("FAIL to_next_pair: got ok=%b res=%h err=%b expected 1,0c0d009c,1", ok, ok ? got_q[0] : res_t'(0), err);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int s0;
    int n;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) push(8'($urandom), 8'($urandom));
    vectors++;
    if (count !== 3'd3 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_queued: got count=%0d busy=%b expected 3,1", count, busy);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    s0 = start_cnt;
    vectors++;
    if (outs_now() !== 64'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_wait_outputs: got %h in_ready=%b expected 0,1", outs_now(), in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (start_cnt != s0 || m_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_start: got starts=%0d mul_ready=%b expected 0,0", start_cnt - s0, m_ready);
    end
    push(8'h9C, 8'h21);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mul_start && n < 40);
    vectors++;
    if (mul_start !== 1'b1 || m_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_issue_gated: got start=%b mul_ready=%b expected 1,1", mul_start, m_ready);
    end
    wait_results(1, 100, ok);
    vectors++;
    if (!ok || got_q[0] !== {8'h9C, 8'h21, 16'h141C}) begin
      miscompares++;
      $display("FAIL rst_after_result: got ok=%b res=%h expected 1,9c21141c", ok, ok ? got_q[0] : res_t'(0));
    end
  endtask

  task automatic test_random_stream();
    bit ok;
    got_q.delete();
    exp_q.delete();
    res_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      while ($urandom_range(1, 0) == 0) begin
        @(posedge clk);
        #1;
      end
      push(8'($urandom), 8'($urandom));
    end
    wait_results(100, 3000, ok);
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (!ok || got_q.size() != 100) begin
      miscompares++;
      $display("FAIL rand_count: got %0d results expected 100", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== {exp_q[i].a, exp_q[i].b, 16'(exp_q[i].a) * 16'(exp_q[i].b)}) begin
        miscompares++;
        $display("FAIL rand[%0d]: got %h expected a=%h b=%h", i, got_q[i], exp_q[i].a, exp_q[i].b);
      end
    end
    vectors++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_idle: got busy=%b err=%b expected 0,0", busy, err);
    end
  endtask

  task automatic test_invariants();
    vectors++;
    if (consec_err != 0) begin
      miscompares++;
      $display("FAIL start_consecutive: got %0d expected 0", consec_err);
    end
    vectors++;
    if (stable_err != 0) begin
      miscompares++;
      $display("FAIL hold_stable: got %0d changes expected 0", stable_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_random_stream();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
